// File: rtl/spi_bus_sequencer.sv
// Bus-master front end for the SPI core: loads a command frame into core memory,
// runs one transfer, polls DONE and streams the captured bytes back out.
module spi_bus_sequencer #(
  parameter int          ABUSWIDTH = 16,
  parameter int unsigned BASEADDR  = 0,
  parameter int          MEM_BYTES = 16,
  parameter int          POLL_GAP  = 4,
  parameter int          TIMEOUT   = 1000000
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic [7:0]           CMD_DATA,
  input  logic                 CMD_VALID,
  input  logic                 CMD_LAST,
  output logic                 CMD_READY,
  output logic [7:0]           RSP_DATA,
  output logic                 RSP_VALID,
  output logic                 RSP_LAST,
  input  logic                 RSP_READY,
  output logic [ABUSWIDTH-1:0] M_ADD,
  output logic [7:0]           M_DATA_OUT,
  output logic                 M_WR,
  output logic                 M_RD,
  input  logic [7:0]           M_DATA_IN,
  input  logic                 CLR_ERR,
  output logic                 BUSY,
  output logic                 ERR_OVF,
  output logic                 ERR_TIMEOUT
);
  // IDLE: wait for frame | LOAD/DRAIN: accept bytes | CFG_LO/CFG_HI/START: program core
  // POLL_WAIT/POLL_RD/POLL_CHK: wait for DONE | RD_ISSUE/RD_CAP/RD_PUSH: stream response
  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_LOAD      = 4'd1;
  localparam logic [3:0] S_DRAIN     = 4'd2;
  localparam logic [3:0] S_CFG_LO    = 4'd3;
  localparam logic [3:0] S_CFG_HI    = 4'd4;
  localparam logic [3:0] S_START     = 4'd5;
  localparam logic [3:0] S_POLL_WAIT = 4'd6;
  localparam logic [3:0] S_POLL_RD   = 4'd7;
  localparam logic [3:0] S_POLL_CHK  = 4'd8;
  localparam logic [3:0] S_RD_ISSUE  = 4'd9;
  localparam logic [3:0] S_RD_CAP    = 4'd10;
  localparam logic [3:0] S_RD_PUSH   = 4'd11;

  localparam int NW = $clog2(MEM_BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [NW-1:0] N_MAX    = NW'(MEM_BYTES);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP - 1);

  localparam logic [ABUSWIDTH-1:0] BASE    = ABUSWIDTH'(BASEADDR);
  localparam logic [ABUSWIDTH-1:0] A_CTRL  = BASE + ABUSWIDTH'(1);
  localparam logic [ABUSWIDTH-1:0] A_BC_LO = BASE + ABUSWIDTH'(3);
  localparam logic [ABUSWIDTH-1:0] A_BC_HI = BASE + ABUSWIDTH'(4);
  localparam logic [ABUSWIDTH-1:0] A_OUT   = BASE + ABUSWIDTH'(16);
  localparam logic [ABUSWIDTH-1:0] A_IN    = BASE + ABUSWIDTH'(16 + MEM_BYTES);

  logic [3:0]           state, state_nxt;
  logic [NW-1:0]        n, n_nxt, n_inc;
  logic [NW-1:0]        j, j_nxt, j_inc;
  logic [TW-1:0]        tmo, tmo_nxt;
  logic [GW-1:0]        gap, gap_nxt;
  logic [ABUSWIDTH-1:0] add_nxt;
  logic [7:0]           dout_nxt, rdat_nxt;
  logic                 wr_nxt, rd_nxt, rvld_nxt, rlast_nxt;
  logic                 ovf_set, tmo_set, tmo_hit;
  logic [15:0]          bitcnt;

  assign n_inc   = n + 1'b1;
  assign j_inc   = j + 1'b1;
  assign tmo_hit = (tmo == '0);
  assign bitcnt  = 16'({n, 3'b000});

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    j_nxt     = j;
    tmo_nxt   = tmo;
    gap_nxt   = gap;
    add_nxt   = M_ADD;
    dout_nxt  = M_DATA_OUT;
    wr_nxt    = 1'b0;
    rd_nxt    = 1'b0;
    rdat_nxt  = RSP_DATA;
    rvld_nxt  = RSP_VALID;
    rlast_nxt = RSP_LAST;
    ovf_set   = 1'b0;
    tmo_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (CMD_VALID) begin
          state_nxt = S_LOAD;
          n_nxt     = '0;
        end
      end
      S_LOAD: begin
        if (CMD_VALID) begin
          wr_nxt   = 1'b1;
          add_nxt  = A_OUT + ABUSWIDTH'(n);
          dout_nxt = CMD_DATA;
          n_nxt    = n_inc;
          if (CMD_LAST) begin
            state_nxt = S_CFG_LO;
          end else if (n_inc == N_MAX) begin
            state_nxt = S_DRAIN;
            ovf_set   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (CMD_VALID && CMD_LAST) state_nxt = S_IDLE;
      end
      S_CFG_LO: begin
        wr_nxt    = 1'b1;
        add_nxt   = A_BC_LO;
        dout_nxt  = bitcnt[7:0];
        state_nxt = S_CFG_HI;
      end
      S_CFG_HI: begin
        wr_nxt    = 1'b1;
        add_nxt   = A_BC_HI;
        dout_nxt  = bitcnt[15:8];
        state_nxt = S_START;
      end
      S_START: begin
        wr_nxt    = 1'b1;
        add_nxt   = A_CTRL;
        dout_nxt  = 8'h01;
        tmo_nxt   = TMO_LOAD;
        gap_nxt   = GAP_LOAD;
        state_nxt = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        if (tmo_hit) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmo_nxt = tmo - 1'b1;
          if (gap == '0) begin
            rd_nxt    = 1'b1;
            add_nxt   = A_CTRL;
            state_nxt = S_POLL_RD;
          end else begin
            gap_nxt = gap - 1'b1;
          end
        end
      end
      S_POLL_RD: begin
        if (tmo_hit) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          tmo_nxt   = tmo - 1'b1;
          state_nxt = S_POLL_CHK;
        end
      end
      S_POLL_CHK: begin
        if (tmo_hit) begin
          tmo_set   = 1'b1;
          state_nxt = S_IDLE;
        end else if (M_DATA_IN[0]) begin
          j_nxt     = '0;
          rd_nxt    = 1'b1;
          add_nxt   = A_IN;
          state_nxt = S_RD_ISSUE;
        end else begin
          tmo_nxt   = tmo - 1'b1;
          gap_nxt   = GAP_LOAD;
          state_nxt = S_POLL_WAIT;
        end
      end
      // read strobes are raised on entry so the data cycle lines up with RD_CAP/POLL_CHK
      S_RD_ISSUE: state_nxt = S_RD_CAP;
      S_RD_CAP: begin
        rdat_nxt  = M_DATA_IN;
        rvld_nxt  = 1'b1;
        rlast_nxt = (j_inc == n);
        state_nxt = S_RD_PUSH;
      end
      S_RD_PUSH: begin
        if (RSP_READY) begin
          rvld_nxt  = 1'b0;
          rlast_nxt = 1'b0;
          j_nxt     = j_inc;
          if (RSP_LAST) begin
            state_nxt = S_IDLE;
          end else begin
            rd_nxt    = 1'b1;
            add_nxt   = A_IN + ABUSWIDTH'(j_inc);
            state_nxt = S_RD_ISSUE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      n           <= '0;
      j           <= '0;
      tmo         <= '0;
      gap         <= '0;
      M_ADD       <= '0;
      M_DATA_OUT  <= '0;
      M_WR        <= 1'b0;
      M_RD        <= 1'b0;
      CMD_READY   <= 1'b0;
      RSP_DATA    <= '0;
      RSP_VALID   <= 1'b0;
      RSP_LAST    <= 1'b0;
      BUSY        <= 1'b0;
      ERR_OVF     <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
    end else begin
      state      <= state_nxt;
      n          <= n_nxt;
      j          <= j_nxt;
      tmo        <= tmo_nxt;
      gap        <= gap_nxt;
      M_ADD      <= add_nxt;
      M_DATA_OUT <= dout_nxt;
      M_WR       <= wr_nxt;
      M_RD       <= rd_nxt;
      CMD_READY  <= (state_nxt == S_LOAD) || (state_nxt == S_DRAIN);
      RSP_DATA   <= rdat_nxt;
      RSP_VALID  <= rvld_nxt;
      RSP_LAST   <= rlast_nxt;
      BUSY       <= (state_nxt != S_IDLE);
      if (ovf_set)      ERR_OVF <= 1'b1;
      else if (CLR_ERR) ERR_OVF <= 1'b0;
      if (tmo_set)      ERR_TIMEOUT <= 1'b1;
      else if (CLR_ERR) ERR_TIMEOUT <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spi_bus_sequencer.sv
// Directed bench for spi_bus_sequencer against a loopback SPI core bus model,
// with queued expected bus writes, reads and response bytes.
module tb_spi_bus_sequencer;
  localparam int BASE = 'h1000;
  localparam int MEMB = 16;

  logic        BUS_CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  CMD_DATA = 8'h00;
  logic        CMD_VALID = 1'b0, CMD_LAST = 1'b0, CMD_READY;
  logic [7:0]  RSP_DATA;
  logic        RSP_VALID, RSP_LAST;
  logic        RSP_READY = 1'b1;
  logic [15:0] M_ADD;
  logic [7:0]  M_DATA_OUT;
  logic        M_WR, M_RD;
  logic [7:0]  M_DATA_IN = 8'h00;
  logic        CLR_ERR = 1'b0;
  logic        BUSY, ERR_OVF, ERR_TIMEOUT;

  spi_bus_sequencer #(
    .ABUSWIDTH(16), .BASEADDR(BASE), .MEM_BYTES(MEMB), .POLL_GAP(4), .TIMEOUT(64)
  ) dut (
    .BUS_CLK(BUS_CLK), .RST(RST),
    .CMD_DATA(CMD_DATA), .CMD_VALID(CMD_VALID), .CMD_LAST(CMD_LAST), .CMD_READY(CMD_READY),
    .RSP_DATA(RSP_DATA), .RSP_VALID(RSP_VALID), .RSP_LAST(RSP_LAST), .RSP_READY(RSP_READY),
    .M_ADD(M_ADD), .M_DATA_OUT(M_DATA_OUT), .M_WR(M_WR), .M_RD(M_RD), .M_DATA_IN(M_DATA_IN),
    .CLR_ERR(CLR_ERR), .BUSY(BUSY), .ERR_OVF(ERR_OVF), .ERR_TIMEOUT(ERR_TIMEOUT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int checks = 0, errors = 0, cyc = 0;
  int poll_cnt = 0, load_cnt = 0, load_first = 0, load_last = 0, cfg_cyc = 0, start_cyc = 0;
  int last_cnt = 0, rsp_cnt = 0;
  bit start_seen = 1'b0, rdy_mode = 1'b0, stuck_done = 1'b0;
  logic [23:0] wr_q[$];
  logic [8:0]  rsp_q[$];
  logic [15:0] rd_q[$];
  logic [7:0]  frame[0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge BUS_CLK) cyc <= cyc + 1;

  // loopback SPI core: after START the input memory mirrors the output memory
  logic [7:0] mem_out[0:MEMB-1] = '{default: 8'h00};
  logic [7:0] mem_in[0:MEMB-1]  = '{default: 8'h00};
  logic [7:0] bc_lo = 8'h00, bc_hi = 8'h00;
  logic       done = 1'b0;
  int         done_cnt = 0;
  wire [15:0] bus_ofs = M_ADD - 16'(BASE);

  always @(posedge BUS_CLK) begin
    if (M_WR) begin
      if (bus_ofs == 16'd1 && M_DATA_OUT[0]) begin
        done     <= 1'b0;
        done_cnt <= 10;
      end
      if (bus_ofs == 16'd3) bc_lo <= M_DATA_OUT;
      if (bus_ofs == 16'd4) bc_hi <= M_DATA_OUT;
      if (bus_ofs >= 16'd16 && bus_ofs < 16'd32) mem_out[bus_ofs[3:0]] <= M_DATA_OUT;
    end
    if (M_RD) begin
      if (bus_ofs == 16'd1) M_DATA_IN <= {7'd0, done};
      else if (bus_ofs >= 16'd32 && bus_ofs < 16'd48) M_DATA_IN <= mem_in[bus_ofs[3:0]];
      else M_DATA_IN <= 8'hEE;
    end
    if (done_cnt != 0) begin
      done_cnt <= done_cnt - 1;
      if (done_cnt == 1) begin
        for (int i = 0; i < MEMB; i++)
          if (i < int'({bc_hi, bc_lo}) / 8) mem_in[i] <= mem_out[i];
        if (!stuck_done) done <= 1'b1;
      end
    end
  end

  logic [23:0] wexp;
  logic [15:0] rexp;
  always @(negedge BUS_CLK) begin
    if (!RST && M_WR) begin
      if (bus_ofs >= 16'd16 && bus_ofs < 16'd32) begin
        if (load_cnt == 0) load_first = cyc;
        load_last = cyc;
        load_cnt++;
      end
      if (bus_ofs == 16'd3) cfg_cyc = cyc;
      if (bus_ofs == 16'd1) begin start_cyc = cyc; start_seen = 1'b1; end
      wexp = (wr_q.size() != 0) ? wr_q.pop_front() : 24'hxxxxxx;
      chk("bus_wr", {bus_ofs, M_DATA_OUT}, wexp);
    end
    if (!RST && M_RD) begin
      if (bus_ofs == 16'd1) poll_cnt++;
      else begin
        rexp = (rd_q.size() != 0) ? rd_q.pop_front() : 16'hxxxx;
        chk("rd_addr", bus_ofs, rexp);
      end
    end
  end

  logic [8:0] rexp_b, held;
  bit rsp_stall = 1'b0, acc_prev = 1'b0;
  always @(negedge BUS_CLK) begin
    if (RST) begin
      rsp_stall = 1'b0;
      acc_prev  = 1'b0;
    end else begin
      if (rsp_stall) chk("rsp_hold", {RSP_VALID, RSP_LAST, RSP_DATA}, {1'b1, held});
      if (acc_prev) chk("rsp_drop", RSP_VALID, 1'b0);
      RSP_READY = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      acc_prev  = RSP_VALID && RSP_READY;
      if (acc_prev) begin
        rexp_b = (rsp_q.size() != 0) ? rsp_q.pop_front() : 9'hxxx;
        chk("rsp_byte", {RSP_LAST, RSP_DATA}, rexp_b);
        rsp_cnt++;
        if (RSP_LAST) last_cnt++;
      end
      rsp_stall = RSP_VALID && !RSP_READY;
      held      = {RSP_LAST, RSP_DATA};
    end
  end

  // mode 0: full transaction, 1: overflow frame, 2: no response expected
  task automatic send_frame(input int len, input int mode);
    logic [15:0] bc;
    int guard;
    bc = 16'(len * 8);
    load_cnt = 0; last_cnt = 0; rsp_cnt = 0; poll_cnt = 0; start_seen = 1'b0;
    for (int i = 0; i < len && i < MEMB; i++) wr_q.push_back({16'(16 + i), frame[i]});
    if (mode != 1) begin
      wr_q.push_back({16'd3, bc[7:0]});
      wr_q.push_back({16'd4, bc[15:8]});
      wr_q.push_back({16'd1, 8'h01});
    end
    if (mode == 0)
      for (int i = 0; i < len; i++) begin
        rsp_q.push_back({i == len - 1, frame[i]});
        rd_q.push_back(16'(32 + i));
      end
    for (int i = 0; i < len; i++) begin
      CMD_VALID = 1'b1;
      CMD_DATA  = frame[i];
      CMD_LAST  = (i == len - 1);
      guard = 0;
      while (!CMD_READY && guard < 50) begin @(posedge BUS_CLK); #1; guard++; end
      chk("cmd_ready", CMD_READY, 1'b1);
      @(posedge BUS_CLK); #1;
    end
    CMD_VALID = 1'b0;
    CMD_LAST  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    do begin @(posedge BUS_CLK); #1; k++; end
    while ((BUSY || rsp_q.size() != 0) && k < 400);
    chk(tag, {BUSY, 1'(rsp_q.size() == 0)}, 2'b01);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("rd_q_empty", rd_q.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (3) @(posedge BUS_CLK);
    #1;
    chk("reset_outs", {M_ADD, M_DATA_OUT, M_WR, M_RD, CMD_READY, RSP_DATA, RSP_VALID,
                       RSP_LAST, BUSY, ERR_OVF, ERR_TIMEOUT}, 64'd0);
    RST = 1'b0;
    repeat (2) @(posedge BUS_CLK);
    #1;

    frame[0] = 8'hA5; frame[1] = 8'h3C; frame[2] = 8'h81;
    send_frame(3, 0);
    wait_idle("t1_idle");
    chk("t1_rsp_cnt", rsp_cnt, 3);
    chk("t1_last_cnt", last_cnt, 1);
    chk("t1_polled", poll_cnt > 0, 1'b1);
    chk("t1_errs", {ERR_OVF, ERR_TIMEOUT}, 2'b00);

    for (int i = 0; i < 16; i++) frame[i] = 8'(i * 17 + 3);
    send_frame(16, 0);
    wait_idle("t2_idle");
    chk("t2_load_cnt", load_cnt, 16);
    chk("t2_load_span", load_last - load_first, 15);
    chk("t2_cfg_follow", cfg_cyc - load_last, 1);
    chk("t2_start_follow", start_cyc - load_last, 3);
    chk("t2_rsp_cnt", rsp_cnt, 16);
    chk("t2_last_cnt", last_cnt, 1);

    for (int i = 0; i < 17; i++) frame[i] = 8'($urandom);
    send_frame(17, 1);
    wait_idle("t3_idle");
    chk("t3_ovf", ERR_OVF, 1'b1);
    chk("t3_no_start", start_seen, 1'b0);
    chk("t3_cmd_ready", CMD_READY, 1'b0);
    frame[0] = 8'h5A; frame[1] = 8'hC3;
    send_frame(2, 0);
    wait_idle("t3b_idle");
    chk("t3b_rsp_cnt", rsp_cnt, 2);
    chk("t3b_ovf_sticky", ERR_OVF, 1'b1);
    CLR_ERR = 1'b1;
    @(posedge BUS_CLK); #1;
    CLR_ERR = 1'b0;
    chk("t3_ovf_clr", ERR_OVF, 1'b0);

    stuck_done = 1'b1;
    frame[0] = 8'h11; frame[1] = 8'h22;
    send_frame(2, 2);
    guard = 0;
    while (!ERR_TIMEOUT && guard < 200) begin @(posedge BUS_CLK); #1; guard++; end
    chk("t4_tmo_flag", ERR_TIMEOUT, 1'b1);
    chk("t4_tmo_window", start_seen && (cyc - start_cyc) <= 64, 1'b1);
    chk("t4_busy", BUSY, 1'b0);
    chk("t4_no_rsp", rsp_cnt, 0);
    chk("t4_wr_q", wr_q.size(), 0);
    stuck_done = 1'b0;
    CLR_ERR = 1'b1;
    @(posedge BUS_CLK); #1;
    CLR_ERR = 1'b0;
    chk("t4_tmo_clr", ERR_TIMEOUT, 1'b0);

    rdy_mode = 1'b1;
    for (int i = 0; i < 8; i++) frame[i] = 8'($urandom);
    send_frame(8, 0);
    wait_idle("t5_idle");
    chk("t5_rsp_cnt", rsp_cnt, 8);
    chk("t5_last_cnt", last_cnt, 1);
    rdy_mode = 1'b0;

    frame[0] = 8'h01; frame[1] = 8'h02; frame[2] = 8'h03;
    send_frame(3, 2);
    guard = 0;
    while (!start_seen && guard < 100) begin @(posedge BUS_CLK); #1; guard++; end
    chk("t6_reached_poll", start_seen, 1'b1);
    RST = 1'b1;
    @(posedge BUS_CLK); #1;
    chk("t6_rst_outs", {M_ADD, M_DATA_OUT, M_WR, M_RD, CMD_READY, RSP_DATA, RSP_VALID,
                        RSP_LAST, BUSY, ERR_OVF, ERR_TIMEOUT}, 64'd0);
    RST = 1'b0;
    @(posedge BUS_CLK); #1;
    chk("t6_idle_after_rst", {BUSY, M_WR, M_RD}, 3'b000);
    frame[0] = 8'hDE; frame[1] = 8'hAD; frame[2] = 8'hBE;
    send_frame(3, 0);
    wait_idle("t6_idle");
    chk("t6_rsp_cnt", rsp_cnt, 3);
    chk("t6_last_cnt", last_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_bus_sequencer.md
# spi_bus_sequencer

Bus-master sequencer that sits directly upstream of the SPI core on the same 8-bit register bus. It turns a byte-stream command frame into one complete SPI transaction: it loads the frame into the SPI core's output memory, programs the bit count, starts the transfer, polls for done, and streams the captured SDO bytes back out as a response frame. The block runs entirely in the BUS_CLK domain and is the only master on its bus segment.

## Interface
Parameters:
- ABUSWIDTH, 16, bus address width.
- BASEADDR, 0, base address of the SPI core.
- MEM_BYTES, 16, SPI core memory size in bytes; this is the maximum frame length.
- POLL_GAP, 4, idle cycles between successive DONE polls (≥1).
- TIMEOUT, 1000000, BUS_CLK cycles allowed from START until DONE is seen.

Ports:
- BUS_CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- CMD_DATA  in  8  command byte.
- CMD_VALID  in  1  command byte valid.
- CMD_LAST  in  1  marks the last byte of a frame.
- CMD_READY  out  1  command byte accepted.
- RSP_DATA  out  8  response byte.
- RSP_VALID  out  1  response byte valid.
- RSP_LAST  out  1  marks the last response byte.
- RSP_READY  in  1  downstream accepts the response byte.
- M_ADD  out  ABUSWIDTH  bus address.
- M_DATA_OUT  out  8  bus write data.
- M_WR  out  1  bus write strobe (one cycle).
- M_RD  out  1  bus read strobe (one cycle).
- M_DATA_IN  in  8  bus read data; valid in the cycle after M_RD.
- CLR_ERR  in  1  clears the error flags.
- BUSY  out  1  high whenever the FSM is not in IDLE.
- ERR_OVF  out  1  sticky: a frame exceeded MEM_BYTES.
- ERR_TIMEOUT  out  1  sticky: DONE was not seen within TIMEOUT.

## Operation
- Register offsets used, all relative to BASEADDR (address arithmetic is mod 2^ABUSWIDTH):
  - 1: START write and DONE read (bit 0).
  - 3, 4: bit count, low and high byte.
  - 16+i: output memory byte i.
  - 16+MEM_BYTES+i: input memory byte i.
  - Offset 0 is never written, because a write there soft-resets the core.
- The block relies on the core's reset defaults (wait = 4, repeat = 1) and never writes the wait or repeat registers.
- FSM states: IDLE, LOAD, DRAIN, CFG_LO, CFG_HI, START, POLL_WAIT, POLL_RD, POLL_CHK, RD_ISSUE, RD_CAP, RD_PUSH.
- IDLE -> LOAD when CMD_VALID=1; the byte counter n is cleared to 0.
- LOAD:
  - CMD_READY=1.
  - Each handshake writes byte n to 16+n and increments n.
  - Handshake with CMD_LAST=1 -> CFG_LO.
  - n reaching MEM_BYTES without LAST -> DRAIN.
  - A frame of exactly MEM_BYTES with LAST on the final byte is legal.
- DRAIN: CMD_READY=1; bytes are discarded up to and including the LAST byte. ERR_OVF is set, no SPI access is made, and the FSM returns to IDLE.
- CFG_LO writes (n*8)[7:0] to offset 3. CFG_HI writes (n*8)[15:8] to offset 4. START writes 0x01 to offset 1 and clears the timeout counter.
- Polling:
  - POLL_WAIT idles for POLL_GAP cycles.
  - POLL_RD issues M_RD to offset 1.
  - POLL_CHK samples M_DATA_IN[0]: 1 -> RD_ISSUE with index j=0; 0 -> POLL_WAIT.
- Timeout: the timeout counter runs from START through POLL_CHK. On reaching TIMEOUT it sets ERR_TIMEOUT, returns to IDLE, and no response is emitted.
- Readback:
  - RD_ISSUE reads offset 16+MEM_BYTES+j.
  - RD_CAP loads M_DATA_IN into RSP_DATA, sets RSP_VALID, and sets RSP_LAST=(j==n-1).
  - RD_PUSH holds until RSP_READY, then increments j. It goes to RD_ISSUE, or to IDLE after the last byte.
- Error flags: ERR_OVF and ERR_TIMEOUT are cleared only by RST or CLR_ERR. If CLR_ERR and a set event occur in the same cycle, the set wins.

## Timing
- Reset values: all outputs are 0 (M_ADD, M_DATA_OUT, M_WR, M_RD, CMD_READY, RSP_*, BUSY, ERR_*) and the FSM is in IDLE.
- RST mid-operation aborts any partial frame or response, and all strobes are low on the next cycle.
- All bus outputs are registered. A CMD handshake at edge k produces a one-cycle M_WR with the matching M_ADD/M_DATA_OUT in cycle k+1.
- LOAD sustains one byte per cycle.
- Bus access timing:
  - CFG_LO, CFG_HI and START are consecutive single-cycle writes immediately after the last load write.
  - At most one M_RD is outstanding.
  - M_DATA_IN is sampled exactly one cycle after M_RD.
- Response handshake:
  - RSP_DATA and RSP_LAST are stable while RSP_VALID=1 and RSP_READY=0.
  - RSP_VALID drops in the cycle after the accepting handshake.
  - Maximum response rate is one byte per 3 cycles.
- CMD_READY=0 outside LOAD and DRAIN; CMD_DATA is ignored there.
- BUSY goes high the cycle after leaving IDLE and goes low the cycle after returning to IDLE.

## Test plan
- 3-byte frame 0xA5, 0x3C, 0x81 (LAST on the 3rd) against an SPI core loopback model (SDO=SDI) -> writes to offsets 16, 17, 18; offset 3 = 0x18; offset 4 = 0x00; offset 1 written; polling runs; reads at 32, 33, 34; RSP = model capture, 3 bytes, RSP_LAST on the 3rd.
- 16-byte frame with CMD_VALID held high -> 16 M_WR in 16 consecutive cycles; offset 3 = 0x80; offset 4 = 0x00; 16 response bytes.
- 17-byte frame -> ERR_OVF=1; no write to offsets 1, 3 or 4; all 17 bytes consumed; the following 2-byte frame completes normally; CLR_ERR clears ERR_OVF.
- Bus model with DONE stuck at 0 and TIMEOUT=64 -> ERR_TIMEOUT=1 within 64 cycles after START; no RSP_VALID; BUSY=0 afterwards.
- Random RSP_READY backpressure on an 8-byte frame -> RSP_DATA stable during stalls; byte order is preserved; exactly one RSP_LAST.
- RST asserted during POLL_WAIT -> next cycle all outputs are 0 and FSM is in IDLE; a subsequent frame runs correctly.
